wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Synthesizable writeback trace capture for the pipelined processor. It records
//  register-file writes (dest reg, data, instruction) in a circular buffer,
//  freezes on a programmable trigger plus a post-trigger window, then streams
//  entries oldest-first over a valid/ready port (to UART/VGA debug logic).
// PARAMETERS
//  DATA_W      32  width of writeback data
//  REG_ADDR_W   5  width of destination register index
//  TAG_W       32  width of instruction tag captured with each entry
//  DEPTH       64  buffer entries; power of two, >=2
//  POST_TRIG   16  events captured after trigger event; 0..DEPTH-1
// PORTS
//  clock        in   1              system clock, all logic on posedge
//  reset        in   1              synchronous, active-high
//  wb_valid     in   1              writeback occurs this cycle
//  stall        in   1              pipeline stalled; wb event ignored when 1
//  wb_reg       in   REG_ADDR_W     destination register
//  wb_data      in   DATA_W         data written
//  wb_instr     in   TAG_W          instruction in WB stage
//  arm          in   1              pulse: clear buffer, start capture
//  trig_mode    in   2              00 manual, 01 reg match, 10 reg+data match, 11 free-run
//  trig_reg     in   REG_ADDR_W     trigger register index
//  trig_data    in   DATA_W         trigger data value
//  trig_manual  in   1              pulse: force trigger (all modes)
//  state_o      out  2              00 IDLE, 01 ARMED, 10 POST, 11 DONE
//  count_o      out  log2(DEPTH)+1  valid entries held
//  rd_valid     out  1              read entry valid
//  rd_ready     in   1              consumer accepts entry
//  rd_reg       out  REG_ADDR_W     entry register
//  rd_data      out  DATA_W         entry data
//  rd_instr     out  TAG_W          entry instruction
//  rd_last      out  1              entry is final one
// BEHAVIOUR
//  Reset: state IDLE, wr_ptr/rd_ptr/count/post_cnt 0, all outputs 0. RAM not cleared.
//  Event = wb_valid & ~stall & (wb_reg != 0). Non-events never written.
//  Trigger hit: 01 event & wb_reg==trig_reg; 10 additionally wb_data==trig_data;
//   11 never from data; trig_manual hits in every mode.
//  arm has top priority in every state: next state ARMED, count/wr_ptr/post_cnt 0,
//   rd_valid 0 next cycle; an event in the arm cycle is discarded.
//  IDLE: no capture; arm -> ARMED.
//  ARMED: each event writes {reg,data,instr} at wr_ptr; wr_ptr+1 mod DEPTH; count
//   saturates at DEPTH, oldest overwritten. On hit: hitting event (if any) is
//   written; POST_TRIG==0 -> DONE, else -> POST, post_cnt 0.
//   Further trig_manual/hits in POST ignored.
//  POST: each event written as in ARMED, post_cnt+1; event making post_cnt==POST_TRIG
//   is written and state -> DONE same edge.
//  DONE: capture stops. rd_ptr = (count==DEPTH) ? wr_ptr : 0 on entry.
//   count==0 -> IDLE next cycle, rd_valid never asserted.
//   Else rd_valid=1 one cycle after entering DONE (registered read), first entry
//   = oldest. Transfer on rd_valid&rd_ready: rd_ptr+1 mod DEPTH, remaining-1,
//   next entry presented next cycle (back-to-back at 1/cycle).
//   rd_last=1 with final entry; after its transfer rd_valid 0, state IDLE.
//   rd_* stable while rd_valid & ~rd_ready.
//  count_o holds captured total through readout; cleared on arm/reset.
//  Reset mid-operation: as reset; prior contents unreadable.
// TESTING (DEPTH=8, POST_TRIG=2)
//  1 reset, arm, events r1=5,r2=7,r3=9, trig_manual, events r4=11,r5=13 -> DONE,
//    count_o=5; reads (1,5)(2,7)(3,9)(4,11)(5,13), rd_last on 5th, then IDLE.
//  2 mode 01 trig_reg=10, events r1..r12 data=reg*2; r10 trigs; r11,r12 -> DONE,
//    count_o=8; reads r5..r12 (data 10..24), wrap verified.
//  3 events with stall=1 or wb_reg=0 interleaved in test 1 -> identical output.
//  4 test 1 with rd_ready low 3 cycles per entry -> rd_* stable, no loss/duplicate.
//  5 arm after 2nd transfer in DONE -> rd_valid 0 next cycle, state_o=01, count_o=0.
//  6 reset asserted in POST -> next cycle state_o=00, count_o=0, rd_valid=0.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// Writeback capture bus and oldest-first readout stream of the trace buffer.
// The master drives writebacks and rd_ready; the slave (the trace buffer) drives the rd_* entry stream.
interface wb_trace_buffer_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TAG_W      = 32
);
  logic                  wb_valid;
  logic                  stall;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic [TAG_W-1:0]      wb_instr;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [REG_ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0]     rd_data;
  logic [TAG_W-1:0]      rd_instr;
  logic                  rd_last;

  modport master (
    output wb_valid, stall, wb_reg, wb_data, wb_instr, rd_ready,
    input  rd_valid, rd_reg, rd_data, rd_instr, rd_last
  );

  modport slave (
    input  wb_valid, stall, wb_reg, wb_data, wb_instr, rd_ready,
    output rd_valid, rd_reg, rd_data, rd_instr, rd_last
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Circular writeback trace with trigger + post-trigger window; readout one cycle after DONE, then 1 entry/cycle.
// rd_* hold steady while rd_ready is low; arm (top priority) and reset abandon any capture or readout.
module wb_trace_buffer #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TAG_W      = 32,
  parameter int DEPTH      = 64,
  parameter int POST_TRIG  = 16
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  wb_trace_buffer_if.slave          trc_if,
  input  logic                      i_arm,
  input  logic [1:0]                i_trig_mode,
  input  logic [REG_ADDR_W-1:0]     i_trig_reg,
  input  logic [DATA_W-1:0]         i_trig_data,
  input  logic                      i_trig_manual,
  output logic [1:0]                o_state,
  output logic [$clog2(DEPTH):0]    o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] PT   = CW'(POST_TRIG);

  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ARMED = 2'b01, S_POST = 2'b10, S_DONE = 2'b11} state_e;

  typedef struct packed {
    logic [TAG_W-1:0]      instr;
    logic [DATA_W-1:0]     data;
    logic [REG_ADDR_W-1:0] rg;
  } entry_t;

  entry_t        r_mem [DEPTH];
  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, r_post_cnt;
  logic [CW-1:0] r_count, r_remaining;
  logic          r_rd_valid;
  entry_t        r_rd_entry;

  logic          w_event, w_hit, w_capture, w_xfer;
  logic [AW-1:0] w_wr_ptr_nxt, w_rd_ptr_inc;
  logic [CW-1:0] w_count_nxt, w_post_inc;

  always_comb begin
    w_event      = trc_if.wb_valid & ~trc_if.stall & (trc_if.wb_reg != '0);
    w_hit        = i_trig_manual |
                   (w_event & (trc_if.wb_reg == i_trig_reg) &
                    ((i_trig_mode == 2'b01) |
                     ((i_trig_mode == 2'b10) & (trc_if.wb_data == i_trig_data))));
    w_capture    = ~i_arm & w_event & ((r_state == S_ARMED) | (r_state == S_POST));
    w_xfer       = r_rd_valid & trc_if.rd_ready;
    w_wr_ptr_nxt = w_capture ? r_wr_ptr + 1'b1 : r_wr_ptr;
    w_count_nxt  = (w_capture && (r_count != FULL)) ? r_count + 1'b1 : r_count;
    w_post_inc   = {1'b0, r_post_cnt} + 1'b1;
    w_rd_ptr_inc = r_rd_ptr + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_ARMED: if (w_hit) w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
        S_POST:  if (w_capture && (w_post_inc == PT)) w_state_nxt = S_DONE;
        S_DONE: begin
          if (r_count == '0) w_state_nxt = S_IDLE;
          else if (w_xfer && (r_remaining == CW'(1))) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Trace RAM is deliberately left uninitialised; reads are gated by count.
  always_ff @(posedge i_clock) begin
    if (w_capture) r_mem[r_wr_ptr] <= '{instr: trc_if.wb_instr, data: trc_if.wb_data, rg: trc_if.wb_reg};
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_remaining <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_entry  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (i_arm) begin
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_post_cnt  <= '0;
        r_remaining <= '0;
        r_rd_valid  <= 1'b0;
      end else begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_count  <= w_count_nxt;
        if (r_state == S_ARMED) r_post_cnt <= '0;
        else if ((r_state == S_POST) && w_capture) r_post_cnt <= w_post_inc[AW-1:0];
        // On a wrapped buffer the oldest entry sits at the write pointer.
        if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
          r_rd_ptr    <= (w_count_nxt == FULL) ? w_wr_ptr_nxt : '0;
          r_remaining <= w_count_nxt;
        end else if (r_state == S_DONE) begin
          if (!r_rd_valid && (r_remaining != '0)) begin
            r_rd_entry <= r_mem[r_rd_ptr];
            r_rd_valid <= 1'b1;
          end else if (w_xfer) begin
            r_remaining <= r_remaining - 1'b1;
            if (r_remaining == CW'(1)) begin
              r_rd_valid <= 1'b0;
            end else begin
              r_rd_ptr   <= w_rd_ptr_inc;
              r_rd_entry <= r_mem[w_rd_ptr_inc];
            end
          end
        end
      end
    end
  end

  assign o_state         = r_state;
  assign o_count         = r_count;
  assign trc_if.rd_valid = r_rd_valid;
  assign trc_if.rd_reg   = r_rd_entry.rg;
  assign trc_if.rd_data  = r_rd_entry.data;
  assign trc_if.rd_instr = r_rd_entry.instr;
  assign trc_if.rd_last  = r_rd_valid & (r_remaining == CW'(1));
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer at DEPTH=8, POST_TRIG=2: directed captures, readout order,
// backpressure stability, arm during readout and reset during the post-trigger window.
module tb_wb_trace_buffer;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TW = 32;
  localparam int DEPTH = 8;
  localparam int PT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_trace_buffer_if #(.DATA_W(DW), .REG_ADDR_W(RW), .TAG_W(TW)) trc();

  logic          arm, trig_manual;
  logic [1:0]    trig_mode;
  logic [RW-1:0] trig_reg;
  logic [DW-1:0] trig_data;
  logic [1:0]    state;
  logic [3:0]    count;

  wb_trace_buffer #(
    .DATA_W(DW), .REG_ADDR_W(RW), .TAG_W(TW), .DEPTH(DEPTH), .POST_TRIG(PT)
  ) dut (
    .i_clock(clk), .i_reset(rst), .trc_if(trc), .i_arm(arm), .i_trig_mode(trig_mode),
    .i_trig_reg(trig_reg), .i_trig_data(trig_data), .i_trig_manual(trig_manual),
    .o_state(state), .o_count(count)
  );

  typedef struct {
    logic [RW-1:0] rg;
    logic [DW-1:0] d;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int n_xfer = 0;

  logic       ready_en = 1'b1;
  logic       slow = 1'b0;
  logic [1:0] slow_cnt = 2'd0;
  always @(posedge clk) slow_cnt <= slow_cnt + 2'd1;
  assign trc.rd_ready = ready_en & (~slow | (slow_cnt == 2'd3));

  function automatic logic [TW-1:0] tag(input logic [RW-1:0] r);
    return 32'hA000_0000 | {27'd0, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted entry and checks that held entries do not change.
  logic          hold_prev = 1'b0;
  logic [RW-1:0] hold_rg;
  logic [DW-1:0] hold_d;
  logic [TW-1:0] hold_i;
  always @(negedge clk) begin
    exp_t e;
    if (hold_prev) begin
      checks++;
      if (!(trc.rd_valid === 1'b1 && trc.rd_reg === hold_rg && trc.rd_data === hold_d && trc.rd_instr === hold_i)) begin
        failures++;
        $display("FAIL hold_stable: got v=%0b r=%0d d=%0d expected v=1 r=%0d d=%0d",
                 trc.rd_valid, trc.rd_reg, trc.rd_data, hold_rg, hold_d);
      end
    end
    hold_prev = trc.rd_valid & ~trc.rd_ready & ~arm & ~rst;
    hold_rg = trc.rd_reg;
    hold_d  = trc.rd_data;
    hold_i  = trc.rd_instr;
    if (trc.rd_valid === 1'b1 && trc.rd_ready === 1'b1) begin
      n_xfer++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got entry r=%0d d=%0d expected no entry", trc.rd_reg, trc.rd_data);
      end else begin
        e = sb.pop_front();
        if (trc.rd_reg !== e.rg || trc.rd_data !== e.d || trc.rd_instr !== tag(e.rg) || trc.rd_last !== e.last) begin
          failures++;
          $display("FAIL rd_entry: got r=%0d d=%0d i=%0h last=%0b expected r=%0d d=%0d i=%0h last=%0b",
                   trc.rd_reg, trc.rd_data, trc.rd_instr, trc.rd_last, e.rg, e.d, tag(e.rg), e.last);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(input logic [RW-1:0] r, input logic [DW-1:0] d, input logic v = 1'b1, input logic st = 1'b0);
    trc.wb_valid = v;
    trc.stall    = st;
    trc.wb_reg   = r;
    trc.wb_data  = d;
    trc.wb_instr = tag(r);
    tick();
    trc.wb_valid = 1'b0;
    trc.stall    = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse_trig();
    trig_manual = 1'b1;
    tick();
    trig_manual = 1'b0;
  endtask

  task automatic push(input logic [RW-1:0] r, input logic [DW-1:0] d, input logic l);
    sb.push_back('{rg: r, d: d, last: l});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (n < budget && state != 2'b00) begin
      tick();
      n++;
    end
    chk(name, 64'(state), 64'd0);
  endtask

  // Baseline capture: r1=5 r2=7 r3=9, manual trigger, r4=11 r5=13; noisy adds non-events.
  task automatic run_t1(input string name, input logic noisy, input int n_push);
    logic [RW-1:0] regs [5];
    logic [DW-1:0] dats [5];
    regs = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    dats = '{32'd5, 32'd7, 32'd9, 32'd11, 32'd13};
    for (int i = 0; i < n_push; i++) push(regs[i], dats[i], i == 4);
    trig_mode = 2'b00;
    pulse_arm();
    ev(5'd1, 32'd5);
    if (noisy) ev(5'd3, 32'd99, 1'b1, 1'b1);
    ev(5'd2, 32'd7);
    if (noisy) ev(5'd0, 32'd55);
    ev(5'd3, 32'd9);
    if (noisy) ev(5'd4, 32'd77, 1'b0, 1'b0);
    pulse_trig();
    if (noisy) ev(5'd6, 32'd1, 1'b1, 1'b1);
    ev(5'd4, 32'd11);
    if (noisy) ev(5'd0, 32'd2);
    ev(5'd5, 32'd13);
    chk({name, "_state_done"}, 64'(state), 64'd3);
    chk({name, "_count"}, 64'(count), 64'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; arm = 1'b0; trig_manual = 1'b0; trig_mode = 2'b00; trig_reg = '0; trig_data = '0;
    trc.wb_valid = 1'b0; trc.stall = 1'b0; trc.wb_reg = '0; trc.wb_data = '0; trc.wb_instr = '0;
    tick(); tick();
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_rd_valid", 64'(trc.rd_valid), 64'd0);
    rst = 1'b0;
    tick();

    run_t1("t1", 1'b0, 5);
    wait_idle("t1_idle", 50);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    trig_mode = 2'b01; trig_reg = 5'd10;
    for (int r = 5; r <= 12; r++) push(RW'(r), DW'(r * 2), r == 12);
    pulse_arm();
    for (int r = 1; r <= 12; r++) ev(RW'(r), DW'(r * 2));
    chk("t2_state_done", 64'(state), 64'd3);
    chk("t2_count", 64'(count), 64'd8);
    wait_idle("t2_idle", 50);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);

    run_t1("t3", 1'b1, 5);
    wait_idle("t3_idle", 50);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    slow = 1'b1;
    run_t1("t4", 1'b0, 5);
    wait_idle("t4_idle", 100);
    slow = 1'b0;
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    base = n_xfer;
    run_t1("t5", 1'b0, 2);
    for (int n = 0; n < 50 && n_xfer < base + 2; n++) tick();
    chk("t5_two_xfers", 64'(n_xfer - base), 64'd2);
    ready_en = 1'b0;
    pulse_arm();
    chk("t5_rd_valid", 64'(trc.rd_valid), 64'd0);
    chk("t5_state", 64'(state), 64'd1);
    chk("t5_count", 64'(count), 64'd0);
    ready_en = 1'b1;
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    trig_mode = 2'b00;
    pulse_arm();
    ev(5'd1, 32'd3);
    pulse_trig();
    chk("t6_state_post", 64'(state), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_state", 64'(state), 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_rd_valid", 64'(trc.rd_valid), 64'd0);
    repeat (5) tick();
    chk("t6_rd_valid_later", 64'(trc.rd_valid), 64'd0);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
